mux6_rr_select: RTL and testbench

- Round-robin arbiter and select generator for a 6:1 bit multiplexer stage: six sources request the shared mux output, this block picks one and drives the 3-bit select (0..5) that feeds the mux select input.
- Holds the grant stable until the consumer signals completion, the owner drops its request, or a watchdog expires.
- Sits directly upstream of the 6:1 mux; guarantees select never takes codes 6 or 7.

---
 rtl/mux6_rr_select_pkg.sv | 33 +++
 rtl/mux6_rr_select_rr_pick6.sv | 24 ++
 rtl/mux6_rr_select.sv | 101 ++++++++++
 tb/tb_mux6_rr_select.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mux6_rr_select_pkg.sv
// Shared types, constants and index helpers for the 6-source round-robin select logic.
package mux6_rr_select_pkg;

    localparam int NUM_SRC = 6;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] MAX_SEL = 3'd5;

    // Next source index, wrapping 5 -> 0 so codes 6/7 never appear.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
        return (s == MAX_SEL) ? '0 : s + 1'b1;
    endfunction

    // (a + b) mod NUM_SRC for a, b in 0..NUM_SRC-1.
    function automatic logic [SEL_W-1:0] add_mod(input logic [SEL_W-1:0] a,
                                                 input logic [SEL_W-1:0] b);
        logic [SEL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, MAX_SEL})
            s = s - (SEL_W+1)'(NUM_SRC);
        return s[SEL_W-1:0];
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] s);
        return NUM_SRC'(1) << s;
    endfunction

endpackage

// File: rtl/mux6_rr_select_rr_pick6.sv
// Rotated priority search: first requesting source at ptr, ptr+1, ... mod 6.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is present.
module rr_pick6
    import mux6_rr_select_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req[add_mod(ptr, SEL_W'(i))]) begin
                found = 1'b1;
                idx   = add_mod(ptr, SEL_W'(i));
            end
        end
    end

endmodule

// File: rtl/mux6_rr_select.sv
// Round-robin arbiter driving the registered 3-bit select of a 6:1 mux.
// Latency: grant appears one edge after a request is seen in IDLE.
// Backpressure: grant held until done, owner request drop, or watchdog expiry.
module mux6_rr_select
    import mux6_rr_select_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_SRC-1:0] grant,
    output logic               sel_valid,
    output logic               timeout
);

    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic               sel_valid_nxt;
    logic               timeout_nxt;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_drop;
    logic               wd_expired;

    rr_pick6 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_drop = !req[sel];
    assign wd_expired = WD_EN && (cnt == CNT_END);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        sel_nxt       = sel;
        grant_nxt     = grant;
        sel_valid_nxt = sel_valid;
        timeout_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = GRANT;
                    sel_nxt       = pick_idx;
                    grant_nxt     = onehot(pick_idx);
                    sel_valid_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            GRANT: begin
                if (done || owner_drop || wd_expired) begin
                    state_nxt     = IDLE;
                    sel_valid_nxt = 1'b0;
                    grant_nxt     = '0;
                    ptr_nxt       = wrap_inc(sel);
                    // Pulse only when the watchdog alone forced the release.
                    timeout_nxt   = wd_expired && !done && !owner_drop;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            sel       <= '0;
            grant     <= '0;
            sel_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            grant     <= grant_nxt;
            sel_valid <= sel_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mux6_rr_select.sv
// Directed bench for mux6_rr_select with a 4-cycle watchdog.
module tb_mux6_rr_select;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] req;
    logic       done;
    logic [2:0] sel;
    logic [5:0] grant;
    logic       sel_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    mux6_rr_select #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .grant     (grant),
        .sel_valid (sel_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        #12;
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (grant !== 6'b0) begin failures++; $display("FAIL reset_grant got=%b exp=000000", grant); end
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sel_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        rst_n = 1'b1;
        tick();
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=0", sel_valid); end
    endtask

    task automatic test_basic();
        req = 6'b000100;
        tick();
        checks++; if (sel !== 3'd2) begin failures++; $display("FAIL basic_sel got=%0d exp=2", sel); end
        checks++; if (grant !== 6'b000100) begin failures++; $display("FAIL basic_grant got=%b exp=000100", grant); end
        checks++; if (sel_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", sel_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL basic_rel_valid got=%b exp=0", sel_valid); end
        checks++; if (grant !== 6'b0) begin failures++; $display("FAIL basic_rel_grant got=%b exp=000000", grant); end
        checks++; if (sel !== 3'd2) begin failures++; $display("FAIL basic_sel_hold got=%0d exp=2", sel); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_rel_timeout got=%b exp=0", timeout); end
        // ptr is now 3, so source 3 beats source 2.
        req = 6'b001100;
        tick();
        checks++; if (sel !== 3'd3) begin failures++; $display("FAIL basic_ptr3 got=%0d exp=3", sel); end
        req = '0;
        tick();
    endtask

    task automatic test_rotation();
        do_reset();
        req = 6'b111111;
        for (int n = 0; n < 7; n++) begin
            tick();
            checks++; if (sel !== 3'(n % 6) || sel_valid !== 1'b1) begin failures++; $display("FAIL rot_grant%0d got=%0d/%b exp=%0d/1", n, sel, sel_valid, n % 6); end
            checks++; if (grant !== (6'b1 << (n % 6))) begin failures++; $display("FAIL rot_onehot%0d got=%b", n, grant); end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL rot_idle%0d got=%b exp=0", n, sel_valid); end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 6'b100000;
        tick();
        checks++; if (sel !== 3'd5) begin failures++; $display("FAIL wrap_src5 got=%0d exp=5", sel); end
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 6'b100001;
        tick();
        checks++; if (sel !== 3'd0 || sel_valid !== 1'b1) begin failures++; $display("FAIL wrap_to0 got=%0d/%b exp=0/1", sel, sel_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        req = '0;
    endtask

    task automatic test_drop();
        do_reset();
        req = 6'b001000;
        tick();
        checks++; if (sel !== 3'd3) begin failures++; $display("FAIL drop_grant got=%0d exp=3", sel); end
        req = '0;
        tick();
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL drop_release got=%b exp=0", sel_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL drop_timeout got=%b exp=0", timeout); end
        req = 6'b011000;
        tick();
        checks++; if (sel !== 3'd4) begin failures++; $display("FAIL drop_ptr4 got=%0d exp=4", sel); end
        req = '0;
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        req = 6'b000010;
        tick();
        checks++; if (sel !== 3'd1 || sel_valid !== 1'b1) begin failures++; $display("FAIL wd_grant got=%0d/%b exp=1/1", sel, sel_valid); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (sel_valid !== 1'b1 || timeout !== 1'b0 || sel !== 3'd1) begin failures++; $display("FAIL wd_hold%0d got=%0d/%b/%b exp=1/1/0", c, sel, sel_valid, timeout); end
            if (c == 1) req = 6'b101010;
            if (c == 3) req = 6'b000010;
        end
        tick();
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL wd_release got=%b exp=0", sel_valid); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wd_pulse got=%b exp=1", timeout); end
        tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_pulse_len got=%b exp=0", timeout); end
        checks++; if (sel_valid !== 1'b1 || sel !== 3'd1) begin failures++; $display("FAIL wd_regrant got=%0d/%b exp=1/1", sel, sel_valid); end
        for (int c = 1; c <= 3; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = '0;
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL wd_done_release got=%b exp=0", sel_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_done_nopulse got=%b exp=0", timeout); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 6'b010000;
        tick();
        checks++; if (sel !== 3'd4 || sel_valid !== 1'b1) begin failures++; $display("FAIL ar_grant got=%0d/%b exp=4/1", sel, sel_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 6'b0) begin failures++; $display("FAIL ar_grant_drop got=%b exp=000000", grant); end
        checks++; if (sel_valid !== 1'b0) begin failures++; $display("FAIL ar_valid_drop got=%b exp=0", sel_valid); end
        req = 6'b111111;
        #3;
        rst_n = 1'b1;
        tick();
        checks++; if (sel !== 3'd0 || sel_valid !== 1'b1) begin failures++; $display("FAIL ar_restart got=%0d/%b exp=0/1", sel, sel_valid); end
        done = 1'b1;
        tick();
        done = 1'b0;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_wrap();
        test_drop();
        test_watchdog();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL sim_time_limit reached");
        $fatal(1, "time limit");
    end

endmodule
